// File: rtl/rename_alias_table_pkg.sv
// Shared sizing and reset rules for the rename alias table and its free list.
// `PHYS_REGS sets the physical register file size (defaults to 32).
`ifndef PHYS_REGS
`define PHYS_REGS 32
`endif

package rename_alias_table_pkg;
    localparam int PHYS_REGS   = `PHYS_REGS;
    localparam int PR_W        = $clog2(PHYS_REGS);
    localparam int NUM_RENAMED = 10;
    localparam int ARCH_BASE   = 2;
    localparam int FIRST_FREE  = 12;
    localparam int FL_DEPTH    = PHYS_REGS - FIRST_FREE;

    // Out of reset, arch register n is backed by phys register n.
    function automatic logic [PR_W-1:0] reset_alias(input int arch);
        return PR_W'(arch);
    endfunction
endpackage

// File: rtl/rename_free_list.sv
// Circular free list of physical registers: up to two pops and two pushes per
// cycle, reset to the ascending run FIRST_FREE..PHYS_REGS-1.
module rename_free_list
    import rename_alias_table_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           pop_cnt,
    input  logic [1:0]           push_en,
    input  logic [1:0][PR_W-1:0] push_data,
    output logic [PR_W-1:0]      head0,
    output logic [PR_W-1:0]      head1,
    output logic [PR_W:0]        count
);
    localparam int PTR_W = $clog2(FL_DEPTH);

    logic [PR_W-1:0]  mem [FL_DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PR_W:0]    count_q;
    logic             acc0, acc1, dropped;
    int               room;

    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= FL_DEPTH) s = s - FL_DEPTH;
        return PTR_W'(s);
    endfunction

    assign head0 = mem[head_q];
    assign head1 = mem[wrap(head_q, 2'd1)];
    assign count = count_q;

    // Slots freed by this cycle's pops are reusable by this cycle's pushes.
    always_comb begin
        room    = FL_DEPTH - int'(count_q) + int'(pop_cnt);
        acc0    = push_en[0] && (room >= 1);
        acc1    = push_en[1] && (room >= (acc0 ? 2 : 1));
        dropped = (push_en[0] && !acc0) || (push_en[1] && !acc1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) mem[i] <= PR_W'(FIRST_FREE + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= (PR_W+1)'(FL_DEPTH);
        end else begin
            if (acc0) mem[tail_q] <= push_data[0];
            if (acc1) mem[acc0 ? wrap(tail_q, 2'd1) : tail_q] <= push_data[1];
            tail_q  <= wrap(tail_q, {1'b0, acc0} + {1'b0, acc1});
            head_q  <= wrap(head_q, pop_cnt);
            count_q <= count_q - (PR_W+1)'(pop_cnt) + (PR_W+1)'(acc0) + (PR_W+1)'(acc1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!dropped) else $error("rename_free_list: push beyond capacity dropped");
    end
endmodule

// File: rtl/rename_alias_table.sv
// Register alias table for arch regs 2..11 plus physical free-list management.
// Define RAT_WB_BYPASS_EN to forward same-cycle writebacks onto rat_done.
module rename_alias_table
    import rename_alias_table_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alloc_valid,
    input  logic [7:0]                    alloc_dest_arch,
    input  logic [1:0]                    alloc_dest_en,
    output logic                          alloc_ready,
    output logic [2*PR_W-1:0]             alloc_phys,
    output logic [2*PR_W-1:0]             alloc_old_phys,
    input  logic                          wb_valid,
    input  logic [PR_W-1:0]               wb_phys,
    input  logic [1:0]                    retire_valid,
    input  logic [2*PR_W-1:0]             retire_phys,
    output logic [NUM_RENAMED-1:0]        rat_done,
    output logic [NUM_RENAMED*PR_W-1:0]   rat_aliases,
    output logic [PR_W:0]                 free_count
);
    logic [NUM_RENAMED-1:0][PR_W-1:0] alias_q;
    logic [NUM_RENAMED-1:0]           done_q, wb_hit;
    logic [1:0][3:0]                  arch, idx;
    logic [1:0]                       eff, push_en, pop_cnt;
    logic [1:0][PR_W-1:0]             phys, old_phys, ret;
    logic [PR_W-1:0]                  head0, head1;
    logic [PR_W:0]                    n_eff;
    logic                             fire;

    assign arch = alloc_dest_arch;
    assign ret  = retire_phys;

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            eff[s] = alloc_dest_en[s] && (arch[s] >= 4'(ARCH_BASE))
                     && (arch[s] < 4'(ARCH_BASE + NUM_RENAMED));
            idx[s] = arch[s] - 4'(ARCH_BASE);
            push_en[s] = retire_valid[s] && (ret[s] > PR_W'(1));
        end
    end

    assign n_eff       = (PR_W+1)'(eff[0]) + (PR_W+1)'(eff[1]);
    assign alloc_ready = free_count >= n_eff;
    assign fire        = alloc_valid && alloc_ready;
    assign pop_cnt     = fire ? {eff[0] & eff[1], eff[0] ^ eff[1]} : 2'd0;

    // Slot1 renames after slot0, so a shared dest sees slot0's new reg as its old one.
    always_comb begin
        phys     = '0;
        old_phys = '0;
        if (fire) begin
            if (eff[0]) begin
                phys[0]     = head0;
                old_phys[0] = alias_q[idx[0]];
            end
            if (eff[1]) begin
                phys[1]     = eff[0] ? head1 : head0;
                old_phys[1] = (eff[0] && idx[0] == idx[1]) ? head0 : alias_q[idx[1]];
            end
        end
    end

    assign alloc_phys     = phys;
    assign alloc_old_phys = old_phys;

    always_comb begin
        for (int i = 0; i < NUM_RENAMED; i++) wb_hit[i] = wb_valid && (alias_q[i] == wb_phys);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RENAMED; i++) alias_q[i] <= reset_alias(i + ARCH_BASE);
            done_q <= '1;
        end else begin
            for (int i = 0; i < NUM_RENAMED; i++) begin
                if (fire && eff[1] && idx[1] == 4'(i)) begin
                    alias_q[i] <= phys[1];
                    done_q[i]  <= 1'b0;
                end else if (fire && eff[0] && idx[0] == 4'(i)) begin
                    alias_q[i] <= phys[0];
                    done_q[i]  <= 1'b0;
                end else if (wb_hit[i]) begin
                    done_q[i]  <= 1'b1;
                end
            end
        end
    end

    assign rat_aliases = alias_q;
`ifdef RAT_WB_BYPASS_EN
    assign rat_done = done_q | wb_hit;
`else
    assign rat_done = done_q;
`endif

    rename_free_list u_free_list (
        .clk       (clk),
        .rst       (rst),
        .pop_cnt   (pop_cnt),
        .push_en   (push_en),
        .push_data (ret),
        .head0     (head0),
        .head1     (head1),
        .count     (free_count)
    );
endmodule
